// File: rtl/lfsr_pkg.sv
// Shared types and the LFSR step function for the burst controller.
// Right-shift Fibonacci form: feedback enters at the MSB.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_TAPS = 8'h1D;

    // Widest LFSR the step function supports; callers zero-extend into it.
    localparam int LFSR_MAX_W = 64;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic                  fb;
        logic [LFSR_MAX_W-1:0] nxt;
        fb  = ^(state & taps);
        nxt = (state >> 1) | (LFSR_MAX_W'(fb) << (width - 1));
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_burst_ctrl_if.sv
// Command and output-stream bundle between a host/consumer and lfsr_burst_ctrl.
// master = host/consumer side, slave = controller side.
interface lfsr_burst_ctrl_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [N-1:0]     cmd_seed;
    logic [N-1:0]     cmd_taps;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             busy;
    logic             done;
    logic             seed_fixed;

    modport master (
        output cmd_valid, cmd_seed, cmd_taps, cmd_count, abort, out_ready,
        input  cmd_ready, out_valid, out_data, busy, done, seed_fixed
    );

    modport slave (
        input  cmd_valid, cmd_seed, cmd_taps, cmd_count, abort, out_ready,
        output cmd_ready, out_valid, out_data, busy, done, seed_fixed
    );
endinterface

// File: rtl/lfsr_core.sv
// N-bit Fibonacci LFSR register: load has priority over step, resets to 1.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] value,
    input  logic         step,
    input  logic [N-1:0] taps,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= N'(1);
        end else if (load) begin
            q <= value;
        end else if (step) begin
            q <= N'(lfsr_next(LFSR_MAX_W'(q), LFSR_MAX_W'(taps), N));
        end
    end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// Streams cmd_count successive LFSR states after a seed/taps command; first word 2 cycles after accept.
// Output holds word and count while out_ready is low; commands are refused (cmd_ready=0) outside IDLE.
module lfsr_burst_ctrl
    import lfsr_pkg::*;
#(
    parameter int           N            = 8,
    parameter int           CNT_W        = 16,
    parameter logic [N-1:0] DEFAULT_TAPS = N'(lfsr_pkg::DEFAULT_TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    lfsr_burst_ctrl_if.slave  bus
);

    state_t           st;
    logic [CNT_W-1:0] remaining;
    logic [N-1:0]     taps_reg;
    logic [N-1:0]     lfsr_q;
    logic [N-1:0]     load_value;
    logic             cmd_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             seed_fixed_reg;
    logic             accept;
    logic             xfer;

    assign accept     = bus.cmd_valid & cmd_ready_reg;
    assign xfer       = out_valid_reg & bus.out_ready;
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign load_value = (bus.cmd_seed == '0) ? N'(1) : bus.cmd_seed;

    lfsr_core #(.N(N)) u_core (
        .clk   (clk),
        .rst   (reset),
        .load  (accept),
        .value (load_value),
        .step  (xfer),
        .taps  (taps_reg),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st             <= IDLE;
            cmd_ready_reg  <= 1'b1;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            seed_fixed_reg <= 1'b0;
            remaining      <= '0;
            taps_reg       <= DEFAULT_TAPS;
        end else begin
            case (st)
                IDLE: begin
                    if (accept) begin
                        taps_reg       <= (bus.cmd_taps == '0) ? DEFAULT_TAPS : bus.cmd_taps;
                        remaining      <= bus.cmd_count;
                        seed_fixed_reg <= (bus.cmd_seed == '0);
                        cmd_ready_reg  <= 1'b0;
                        if (bus.cmd_count == '0) begin
                            st       <= DONE;
                            done_reg <= 1'b1;
                        end else begin
                            st       <= LOAD;
                            busy_reg <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        st            <= IDLE;
                        busy_reg      <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                    end else begin
                        st            <= RUN;
                        out_valid_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                    // Abort wins over completion: a transfer in the abort cycle counts, but no done pulse.
                    if (bus.abort) begin
                        st            <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                    end else if (xfer && remaining == CNT_W'(1)) begin
                        st            <= DONE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                    end
                end
                DONE: begin
                    st            <= IDLE;
                    done_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
                default: begin
                    st            <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_valid_reg ? lfsr_q : '0;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.seed_fixed = seed_fixed_reg;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed, table-driven bench for lfsr_burst_ctrl with hand-computed LFSR sequences.
module tb_lfsr_burst_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lfsr_burst_ctrl_if #(.N(8), .CNT_W(16)) bus ();

    lfsr_burst_ctrl #(.N(8), .CNT_W(16), .DEFAULT_TAPS(8'h1D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0]  seed;
        logic [7:0]  taps;
        logic [15:0] count;
        logic [7:0]  exp_words [6];
        logic        exp_fixed;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent bit-loop model of the right-shift Fibonacci step.
    function automatic logic [7:0] model_next(input logic [7:0] s, input logic [7:0] t);
        logic fb;
        fb = 1'b0;
        for (int b = 0; b < 8; b++) fb = fb ^ (s[b] & t[b]);
        return {fb, s[7:1]};
    endfunction

    task automatic send_cmd(input logic [7:0] seed, input logic [7:0] taps,
                            input logic [15:0] count, input string tag);
        chk({tag, "_ready_before"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_seed  = seed;
        bus.cmd_taps  = taps;
        bus.cmd_count = count;
        tick();
        bus.cmd_valid = 1'b0;
        chk({tag, "_seed_fixed"}, 32'(bus.seed_fixed), 32'(seed == 8'h00));
        chk({tag, "_ready_after"}, 32'(bus.cmd_ready), 32'd0);
    endtask

    task automatic run_burst(input vec_t v, input int stall, input string tag);
        send_cmd(v.seed, v.taps, v.count, tag);
        chk({tag, "_load_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_load_valid"}, 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        tick();
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_stall_data"}, 32'(bus.out_data), 32'(v.exp_words[0]));
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < int'(v.count); i++) begin
            chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_word"}, 32'(bus.out_data), 32'(v.exp_words[i]));
            tick();
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done_ready"}, 32'(bus.cmd_ready), 32'd0);
        tick();
        chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] m;
        logic       seen [256];
        int         dups;

        bus.cmd_valid = 1'b0;
        bus.cmd_seed  = '0;
        bus.cmd_taps  = '0;
        bus.cmd_count = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;

        vecs[0] = '{8'h01, 8'h1D, 16'd6, '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88}, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 16'd2, '{8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};
        vecs[2] = '{8'h80, 8'h1D, 16'd3, '{8'h80, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00}, 1'b0};
        vecs[3] = '{8'hFF, 8'h1D, 16'd4, '{8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h00, 8'h00}, 1'b0};
        vecs[4] = '{8'h03, 8'h03, 16'd4, '{8'h03, 8'h01, 8'h80, 8'h40, 8'h00, 8'h00}, 1'b0};
        vecs[5] = '{8'h05, 8'h00, 16'd3, '{8'h05, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00}, 1'b0};

        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_fixed", 32'(bus.seed_fixed), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

        for (int k = 0; k < 6; k++) begin
            run_burst(vecs[k], 0, $sformatf("vec%0d", k));
        end

        // Backpressure on the first three RUN cycles.
        run_burst(vecs[0], 3, "bp");

        // Full period: word 256 wraps back to the seed, no zero, no repeats before that.
        send_cmd(8'h01, 8'h1D, 16'd256, "period");
        tick();
        m    = 8'h01;
        dups = 0;
        for (int j = 0; j < 256; j++) seen[j] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            chk("period_word", 32'(bus.out_data), 32'(m));
            chk("period_nonzero", 32'(bus.out_data != 8'h00), 32'd1);
            if (i < 255) begin
                if (seen[bus.out_data]) dups++;
                seen[bus.out_data] = 1'b1;
            end else begin
                chk("period_wrap", 32'(bus.out_data), 32'h01);
            end
            m = model_next(m, 8'h1D);
            tick();
        end
        chk("period_distinct_dups", 32'(dups), 32'd0);
        chk("period_done", 32'(bus.done), 32'd1);
        tick();

        // Zero-length command: straight to a done pulse, never valid.
        send_cmd(8'h42, 8'h1D, 16'd0, "cnt0");
        chk("cnt0_done", 32'(bus.done), 32'd1);
        chk("cnt0_valid", 32'(bus.out_valid), 32'd0);
        chk("cnt0_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("cnt0_done_drop", 32'(bus.done), 32'd0);
        chk("cnt0_valid2", 32'(bus.out_valid), 32'd0);
        chk("cnt0_ready", 32'(bus.cmd_ready), 32'd1);

        // Abort during word 3 of a 10-word burst.
        send_cmd(8'h01, 8'h1D, 16'd10, "abort");
        tick();
        bus.out_ready = 1'b1;
        chk("abort_w1", 32'(bus.out_data), 32'h01);
        tick();
        chk("abort_w2", 32'(bus.out_data), 32'h80);
        tick();
        chk("abort_w3", 32'(bus.out_data), 32'h40);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        chk("abort_done_late", 32'(bus.done), 32'd0);

        // Abort coinciding with the final transfer suppresses done.
        send_cmd(8'h01, 8'h1D, 16'd3, "abort_last");
        tick();
        tick();
        tick();
        chk("abort_last_w3", 32'(bus.out_data), 32'h40);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_last_done", 32'(bus.done), 32'd0);
        chk("abort_last_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("abort_last_done2", 32'(bus.done), 32'd0);
        chk("abort_last_ready", 32'(bus.cmd_ready), 32'd1);

        // Abort while idle is ignored: next command still works.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_idle_ready", 32'(bus.cmd_ready), 32'd1);

        // Asynchronous reset in the middle of a zero-seed burst.
        send_cmd(8'h00, 8'h00, 16'd10, "rstmid");
        tick();
        tick();
        chk("rstmid_w2", 32'(bus.out_data), 32'h80);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid_data", 32'(bus.out_data), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_done", 32'(bus.done), 32'd0);
        chk("rstmid_fixed", 32'(bus.seed_fixed), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rstmid_valid2", 32'(bus.out_valid), 32'd0);

        run_burst(vecs[0], 1, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
